// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed seven-segment scanner for the countdown timer's packed BCD word.
// Shows hh.mm.ss, optionally blanks a leading hour zero, and blinks the display while the alarm is active.
module bcd_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [23:0] i_bcd_digits,
  input  logic        i_alarm,
  input  logic        i_blank_lz,
  output logic [6:0]  o_seg_n,
  output logic        o_dp_n,
  output logic [5:0]  o_dig_en_n
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [23:0]   r_snap;
  logic [23:0]   r_prev;
  logic          r_alm_s1;
  logic          r_alm_s2;
  logic          r_blink_on;
  logic [FW-1:0] r_frame_cnt;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_dark;
  logic          w_lz_blank;
  logic [5:0]    w_onehot_n;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 3'd5);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Only accept a word that was stable across two clocks, so a 1 Hz update
  // landing on the wrap edge is deferred to the next frame instead of tearing.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev <= '0;
      r_snap <= '0;
    end else begin
      r_prev <= i_bcd_digits;
      if (w_wrap && (i_bcd_digits == r_prev)) r_snap <= i_bcd_digits;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_alm_s1    <= 1'b0;
      r_alm_s2    <= 1'b0;
      r_blink_on  <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      r_alm_s1 <= i_alarm;
      r_alm_s2 <= r_alm_s1;
      if (!r_alm_s2) begin
        r_blink_on  <= 1'b1;
        r_frame_cnt <= '0;
      end else if (w_wrap) begin
        if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          r_blink_on  <= ~r_blink_on;
          r_frame_cnt <= '0;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  always_comb begin
    w_nib = 4'd0;
    case (r_idx)
      3'd0:    w_nib = r_snap[3:0];
      3'd1:    w_nib = r_snap[7:4];
      3'd2:    w_nib = r_snap[11:8];
      3'd3:    w_nib = r_snap[15:12];
      3'd4:    w_nib = r_snap[19:16];
      3'd5:    w_nib = r_snap[23:20];
      default: w_nib = 4'd0;
    endcase
  end

  always_comb begin
    w_seg = 7'h3F;
    case (w_nib)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end

  // Gating with the synced alarm lets the display come back the edge after
  // the alarm drops, without waiting for blink_on to catch up.
  assign w_dark     = ~r_blink_on & r_alm_s2;
  assign w_lz_blank = (r_idx == 3'd5) & i_blank_lz & (r_snap[23:20] == 4'd0);
  assign w_onehot_n = ~(6'b000001 << r_idx);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_seg_n    <= 7'h7F;
      o_dp_n     <= 1'b1;
      o_dig_en_n <= 6'h3F;
    end else if (w_lz_blank) begin
      o_seg_n    <= 7'h7F;
      o_dp_n     <= 1'b1;
      o_dig_en_n <= 6'h3F;
    end else begin
      o_seg_n    <= w_seg;
      o_dp_n     <= ~((r_idx == 3'd2) | (r_idx == 3'd4));
      o_dig_en_n <= ((r_presc == '0) | w_dark) ? 6'h3F : w_onehot_n;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: a scan-position model derived from cycle count since
// reset, checked every cycle, plus literal spot checks for the documented scenarios.
module tb_bcd_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic        clk;
  logic        rst;
  logic [23:0] bcd;
  logic        alarm;
  logic        blank;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  en_n;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  bcd_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .i_clock(clk), .i_reset(rst), .i_bcd_digits(bcd), .i_alarm(alarm),
    .i_blank_lz(blank), .o_seg_n(seg_n), .o_dp_n(dp_n), .o_dig_en_n(en_n)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return tab[d];
  endfunction

  // Reference model: scan position is pure arithmetic on edges since reset.
  int         m_n;
  logic [23:0] m_snap, m_prev;
  logic        m_s1, m_s2, m_blink;
  int          m_fcnt;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [5:0]  e_en;
  int          p, ix;
  bit          wrap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_snap = '0; m_prev = '0; m_s1 = 0; m_s2 = 0; m_blink = 1; m_fcnt = 0;
      e_seg = 7'h7F; e_dp = 1; e_en = 6'h3F;
    end else begin
      p    = m_n % SD;
      ix   = (m_n / SD) % 6;
      wrap = (p == SD - 1) && (ix == 5);
      e_seg = seg_of(m_snap[4*ix +: 4]);
      e_dp  = !(ix == 2 || ix == 4);
      e_en  = 6'h3F ^ (6'd1 << ix);
      if (p == 0 || (!m_blink && m_s2)) e_en = 6'h3F;
      if (ix == 5 && blank && m_snap[23:20] == 4'd0) begin
        e_en = 6'h3F; e_seg = 7'h7F; e_dp = 1;
      end
      if (wrap && bcd == m_prev) m_snap = bcd;
      m_prev = bcd;
      if (!m_s2) begin
        m_blink = 1; m_fcnt = 0;
      end else if (wrap) begin
        if (m_fcnt == BF - 1) begin m_blink = !m_blink; m_fcnt = 0; end
        else m_fcnt = m_fcnt + 1;
      end
      m_s2 = m_s1;
      m_s1 = alarm;
      m_n  = m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({seg_n, dp_n, en_n} !== {e_seg, e_dp, e_en}) begin
        failures++;
        if (failures < 30)
          $display("FAIL model t=%0t n=%0d got seg=%h dp=%b en=%h want seg=%h dp=%b en=%h",
                   $time, m_n, seg_n, dp_n, en_n, e_seg, e_dp, e_en);
      end
    end
  end

  task automatic lit(input string name, input logic [6:0] s, input logic d, input logic [5:0] e);
    checks++;
    if ({seg_n, dp_n, en_n} !== {s, d, e}) begin
      failures++;
      $display("FAIL %s got seg=%h dp=%b en=%h want seg=%h dp=%b en=%h",
               name, seg_n, dp_n, en_n, s, d, e);
    end
  endtask

  task automatic wait_n(input int target);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_n == target) break;
    end
    if (k == 200) begin
      failures++;
      $display("FAIL wait_n timeout target=%0d got n=%0d", target, m_n);
    end
  endtask

  task automatic wait_slot(input int pos);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_n > 0 && ((m_n - 1) % FRAME) == pos) break;
    end
    if (k == 60) begin
      failures++;
      $display("FAIL wait_slot timeout pos=%0d", pos);
    end
  endtask

  initial begin
    rst = 1; bcd = 24'h012345; alarm = 0; blank = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    lit("reset_state", 7'h7F, 1'b1, 6'h3F);
    rst = 0;

    // First frame shows the zero snapshot, second frame shows the word.
    wait_n(1);  lit("f0_slot0_blank", 7'h40, 1'b1, 6'h3F);
    wait_n(2);  lit("f0_slot0_on",    7'h40, 1'b1, 6'h3E);
    wait_n(26); lit("f1_idx0",        7'h12, 1'b1, 6'h3E);
    wait_n(34); lit("f1_idx2_dp",     7'h30, 1'b0, 6'h3B);
    wait_n(42); lit("f1_idx4_dp",     7'h79, 1'b0, 6'h2F);
    wait_n(46); lit("f1_idx5",        7'h40, 1'b1, 6'h1F);

    bcd = 24'h005959; blank = 1;
    repeat (60) @(negedge clk);
    wait_slot(21); lit("lz_blank_idx5", 7'h7F, 1'b1, 6'h3F);
    wait_slot(17); lit("hr0_not_blank", 7'h40, 1'b0, 6'h2F);

    // Word changes one clock before the wrap: old word stays for one more frame.
    wait_slot(22); bcd = 24'h123456;
    wait_slot(1);  lit("torn_keep_old", 7'h10, 1'b1, 6'h3E);
    wait_slot(1);  lit("torn_new_word", 7'h02, 1'b1, 6'h3E);

    bcd = 24'h00000A; blank = 0;
    repeat (60) @(negedge clk);
    wait_slot(2); lit("dash_nibble", 7'h3F, 1'b1, 6'h3E);

    wait_slot(23); alarm = 1;
    wait_slot(10); lit("alarm_f1_on", 7'h40, 1'b0, 6'h3B);
    wait_slot(10); lit("alarm_f2_on", 7'h40, 1'b0, 6'h3B);
    wait_slot(10); lit("alarm_f3_dark", 7'h40, 1'b0, 6'h3F);
    alarm = 0;
    repeat (3) @(negedge clk);
    lit("alarm_drop_resume", 7'h40, 1'b1, 6'h37);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) bcd = $urandom;
      if ($urandom_range(49) == 0) blank = !blank;
      if ($urandom_range(149) == 0) alarm = !alarm;
      if ($urandom_range(59) == 0) bcd[23:20] = 4'd0;
    end

    alarm = 0; bcd = 24'h012345; blank = 0;
    repeat (10) @(negedge clk);
    wait_slot(13);
    @(posedge clk);
    #3 rst = 1;
    #1 lit("async_reset", 7'h7F, 1'b1, 6'h3F);
    repeat (3) @(negedge clk);
    rst = 0;
    wait_n(1); lit("post_reset_slot0", 7'h40, 1'b1, 6'h3F);
    wait_n(2); lit("post_reset_on",    7'h40, 1'b1, 6'h3E);
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Reads the 24-bit packed BCD time word {hr1,hr0,min1,min0,sec1,sec0} and the alarm flag that the countdown timer produces.
- Drives a 6-digit, common-anode, multiplexed seven-segment display.
- Scans one digit at a time, shows decimal points as hh.mm.ss separators, and optionally blanks a leading hour zero.
- Blinks the whole display while the alarm is active. Runs on the fast board clock, not the 1 Hz timer clock.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot. Legal range is 2 or more.
- BLINK_FRAMES, 64: full scan frames per blink half-period while alarm is active. Legal range is 1 or more.

Ports:
- clock  input  1  board clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- bcd_digits  input  24  {hr1,hr0,min1,min0,sec1,sec0}, 4 bits each, sec0 in [3:0]; comes from the 1 Hz domain and changes at most once per second.
- alarm  input  1  alarm flag from the 1 Hz domain.
- blank_lz  input  1  when 1, hr1 is blanked if it is zero.
- seg_n  output  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- dig_en_n  output  6  digit enables, active-low; bit i selects digit i (0 = sec0, 5 = hr1).

Behaviour:
- Reset values (asynchronous, while reset=1):
  - prescaler=0, idx=0, snapshot=0, prev_word=0.
  - alarm sync flops=0, blink_on=1, frame_cnt=0.
  - seg_n=7'h7F, dp_n=1, dig_en_n=6'h3F.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (prescaler==SCAN_DIV-1).
  - On tick, idx advances 0→1→…→5→0.
  - Frame period is 6*SCAN_DIV clocks.
- Alarm input: passes through a 2-flop synchronizer; alarm_s lags alarm by 2 clocks.
- Word capture:
  - prev_word <= bcd_digits every clock.
  - On the edge where tick and idx==5 (frame wrap), snapshot <= bcd_digits only if bcd_digits==prev_word.
  - Otherwise snapshot holds its value and capture is retried at the next frame wrap.
  - The display never shows a torn word.
- Outputs are registered. On each edge they are computed from the pre-edge state:
  - digit value d = snapshot[4*idx+3 : 4*idx].
  - seg_n = decode(d).
  - dp_n = 0 when idx==2 or idx==4, else 1.
  - dig_en_n = ~(6'b1 << idx), except all ones in any of these cases:
    - prescaler==0 (one-clock anti-ghost blank at the start of each slot);
    - blink_on==0;
    - idx==5 with blank_lz==1 and hr1==0. In this case seg_n=7'h7F and dp_n=1 as well.
- Decode table, active-low seg_n hex:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - 10..15 → 3F (segment g only, shows a dash).
- Blink:
  - If alarm_s==0: blink_on<=1 and frame_cnt<=0 every clock.
  - If alarm_s==1: at each frame wrap, frame_cnt increments. When frame_cnt==BLINK_FRAMES-1, blink_on toggles and frame_cnt<=0.
  - The first dark phase therefore starts BLINK_FRAMES frame wraps after alarm_s rises.
- Alarm deassertion mid-dark-phase: the display re-enables on the next edge after alarm_s falls. There is no wait for the frame end.
- Reset mid-scan: everything returns to reset values immediately. After release, scanning restarts at idx=0 with snapshot=0, so digits show 0 until the first frame wrap.
- No other inputs affect the scan timing.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Reset release, bcd_digits=24'h012345 held, blank_lz=0:
  - First frame shows all digits seg_n=40 (snapshot=0).
  - From the second frame: idx0 seg_n=12, idx1 19, idx2 30 with dp_n=0, idx3 24, idx4 79 with dp_n=0, idx5 40.
  - dig_en_n is 3F for exactly one clock per slot, then the one-hot-low value for 3 clocks.
- bcd_digits=24'h005959, blank_lz=1 → slot idx5 gives dig_en_n=3F, seg_n=7F. Slot idx4 shows seg_n=40 (hr0 not blanked).
- bcd_digits changes on the clock just before a frame wrap → snapshot keeps the old word this frame and the new word is shown from the following frame.
- bcd_digits=24'h00000A → idx0 seg_n=3F.
- alarm raised and held → after 2 sync clocks plus 2 frame wraps, dig_en_n stays 3F for 2 full frames, then scanning resumes for 2 frames, repeating. Dropping alarm mid-dark → scanning resumes within 3 clocks.
- reset pulsed during slot idx3 → outputs go to 7F/1/3F asynchronously. After release, idx=0 and the first slot shows seg_n=40.
